ber_stat_aggregator: RTL

Pipelined, saturating aggregator for the per-core BER statistics of an N-core parallel simulator, with run control and coherent snapshots. It takes the five 64-bit counters of every core (bits, pre-FEC bit errors, post-FEC bit errors, frames, frame errors) and reduces them through a registered adder tree. It drives the cores' shared enable and stops the run automatically once a frame-error target is reached. It sits between the core array and the host-visible register interface, replacing the combinational adder chain.

---
 rtl/ber_stat_pkg.sv | 47 ++++
 rtl/ber_sat_add_tree.sv | 48 ++++
 rtl/ber_stat_aggregator.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ber_stat_pkg.sv
// Shared definitions for the BER statistics aggregator: stat indices, run-control
// states and the saturating/log2 helpers used to size and build the adder trees.
package ber_stat_pkg;

  localparam int N_STATS     = 5;
  localparam int STAT_BITS   = 0;
  localparam int STAT_PRE    = 1;
  localparam int STAT_POST   = 2;
  localparam int STAT_FRAMES = 3;
  localparam int STAT_FERR   = 4;
  localparam int MAX_W       = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Unsigned add clamped to 2^w-1; callers zero-extend narrower operands to MAX_W.
  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int w);
    logic [MAX_W:0] s;
    logic [MAX_W:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
    return (s > lim) ? lim[MAX_W-1:0] : s[MAX_W-1:0];
  endfunction

  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Number of nodes remaining after lvl rounds of pairwise reduction.
  function automatic int level_width(input int n, input int lvl);
    int w;
    w = n;
    for (int i = 0; i < lvl; i++) w = (w + 1) / 2;
    return w;
  endfunction

endpackage

// File: rtl/ber_sat_add_tree.sv
// Pipelined saturating adder tree for one statistic: an input register stage
// followed by one registered level of pairwise sums per tree level.
module ber_sat_add_tree
  import ber_stat_pkg::*;
#(
  parameter int N_IN  = 10,
  parameter int CNT_W = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_IN*CNT_W-1:0] in_vec,
  output logic [CNT_W-1:0]      sum
);

  localparam int LVL = ceil_log2(N_IN);

  for (genvar gl = 0; gl <= LVL; gl++) begin : g_lvl
    localparam int W  = level_width(N_IN, gl);
    localparam int WP = (gl == 0) ? N_IN : level_width(N_IN, gl - 1);

    for (genvar gi = 0; gi < W; gi++) begin : g_node
      logic [CNT_W-1:0] q_reg;

      if (gl == 0) begin : g_leaf
        always_ff @(posedge clk) begin
          if (!rstn) q_reg <= '0;
          else       q_reg <= in_vec[gi*CNT_W +: CNT_W];
        end
      end else if (2*gi + 1 < WP) begin : g_pair
        always_ff @(posedge clk) begin
          if (!rstn) q_reg <= '0;
          else       q_reg <= CNT_W'(sat_add(MAX_W'(g_lvl[gl-1].g_node[2*gi].q_reg),
                                             MAX_W'(g_lvl[gl-1].g_node[2*gi+1].q_reg),
                                             CNT_W));
        end
      end else begin : g_pass
        // Odd leftover node is delayed so every path has the same latency.
        always_ff @(posedge clk) begin
          if (!rstn) q_reg <= '0;
          else       q_reg <= g_lvl[gl-1].g_node[2*gi].q_reg;
        end
      end
    end
  end

  assign sum = g_lvl[LVL].g_node[0].q_reg;

endmodule

// File: rtl/ber_stat_aggregator.sv
// Sums per-core BER counters through pipelined saturating trees, drives the core
// enable with auto-stop on a frame-error target, and takes coherent snapshots.
module ber_stat_aggregator
  import ber_stat_pkg::*;
#(
  parameter int N_CORES  = 10,
  parameter int CNT_W    = 64,
  parameter int STOP_IDX = STAT_FERR
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic                          clear,
  input  logic [CNT_W-1:0]              stop_target,
  input  logic [N_CORES*N_STATS*CNT_W-1:0] stats_in,
  input  logic                          snap_req,
  output logic                          core_en,
  output logic [1:0]                    state,
  output logic [N_STATS*CNT_W-1:0]      totals,
  output logic                          totals_valid,
  output logic [N_STATS*CNT_W-1:0]      snap_data,
  output logic [CNT_W-1:0]              snap_cycles,
  output logic                          snap_valid,
  output logic                          snap_busy,
  output logic [CNT_W-1:0]              run_cycles
);

  localparam int L = ceil_log2(N_CORES) + 1;

  // Regroup core-major input into one column per statistic.
  for (genvar gi = 0; gi < N_STATS; gi++) begin : g_stat
    logic [N_CORES*CNT_W-1:0] col;
    for (genvar gc = 0; gc < N_CORES; gc++) begin : g_core
      assign col[gc*CNT_W +: CNT_W] = stats_in[(gc*N_STATS + gi)*CNT_W +: CNT_W];
    end
    ber_sat_add_tree #(.N_IN(N_CORES), .CNT_W(CNT_W)) u_tree (
      .clk    (clk),
      .rstn   (rstn),
      .in_vec (col),
      .sum    (totals[gi*CNT_W +: CNT_W])
    );
  end

  logic [L-1:0] vld_reg;
  always_ff @(posedge clk) begin
    if (!rstn) vld_reg <= '0;
    else       vld_reg <= (vld_reg << 1) | L'(1);
  end
  assign totals_valid = vld_reg[L-1];

  state_t           state_reg, state_next;
  logic             core_en_reg;
  logic [CNT_W-1:0] run_cycles_reg;
  logic             stop_hit;

  assign stop_hit = totals_valid && (stop_target != '0) &&
                    (totals[STOP_IDX*CNT_W +: CNT_W] >= stop_target);

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (stop_hit) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      core_en_reg    <= 1'b0;
      run_cycles_reg <= '0;
    end else begin
      state_reg   <= state_next;
      core_en_reg <= (state_next == RUN);
      if (clear)
        run_cycles_reg <= '0;
      else if (state_reg == RUN && run_cycles_reg != '1)
        run_cycles_reg <= run_cycles_reg + 1'b1;
    end
  end

  assign state      = state_reg;
  assign core_en    = core_en_reg;
  assign run_cycles = run_cycles_reg;

  // Capture happens once the request-cycle inputs have reached the tree output.
  localparam logic [7:0] SNAP_WAIT = 8'(L - 1);

  logic [7:0]               snap_cnt_reg;
  logic [CNT_W-1:0]         snap_latch_reg;
  logic [N_STATS*CNT_W-1:0] snap_data_reg;
  logic [CNT_W-1:0]         snap_cycles_reg;
  logic                     snap_valid_reg;
  logic                     snap_busy_reg;

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      snap_cnt_reg    <= '0;
      snap_latch_reg  <= '0;
      snap_data_reg   <= '0;
      snap_cycles_reg <= '0;
      snap_valid_reg  <= 1'b0;
      snap_busy_reg   <= 1'b0;
    end else begin
      snap_valid_reg <= 1'b0;
      if (snap_busy_reg) begin
        if (snap_cnt_reg == '0) begin
          snap_data_reg   <= totals;
          snap_cycles_reg <= snap_latch_reg;
          snap_valid_reg  <= 1'b1;
          snap_busy_reg   <= 1'b0;
        end else begin
          snap_cnt_reg <= snap_cnt_reg - 1'b1;
        end
      end else if (snap_req) begin
        snap_busy_reg  <= 1'b1;
        snap_cnt_reg   <= SNAP_WAIT;
        snap_latch_reg <= run_cycles_reg;
      end
    end
  end

  assign snap_data   = snap_data_reg;
  assign snap_cycles = snap_cycles_reg;
  assign snap_valid  = snap_valid_reg;
  assign snap_busy   = snap_busy_reg;

endmodule
